// File: rtl/tlu_trigger_data_receiver.sv
// TLU trigger-number receiver: clocks N bits in from the TLU, compensates the pipeline and offers the word on valid/ready.
// Optional build macro TLU_SEQ_CHECK_EN enables the consecutive-trigger-number check that drives SEQ_ERR.
module tlu_trigger_data_receiver #(
    parameter int DATA_WIDTH    = 32,
    parameter int CNT_WIDTH     = 6,
    parameter int DELAY_WIDTH   = 4,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic [CNT_WIDTH-1:0]     CFG_CLOCK_CYCLES,
    input  logic [DELAY_WIDTH-1:0]   CFG_DATA_DELAY,
    input  logic                     CFG_MSB_FIRST,
    input  logic [TIMEOUT_WIDTH-1:0] CFG_TIMEOUT,
    input  logic                     TLU_TRIGGER,
    input  logic                     START,
    output logic                     TLU_CLOCK_ENABLE,
    output logic                     BUSY,
    output logic [DATA_WIDTH-1:0]    TLU_DATA,
    output logic                     DATA_VALID,
    input  logic                     DATA_READY,
    output logic                     DONE,
    output logic                     TIMEOUT_ERR,
    output logic                     SEQ_ERR,
    output logic [2:0]               dbg_state
);

    // Handshake: a word transfers on any rising CLK edge where DATA_VALID && DATA_READY;
    // DATA_VALID and TLU_DATA stay stable until then, and READY never feeds back into VALID combinationally.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLOCK = 3'd1,
        S_WAIT  = 3'd2,
        S_LATCH = 3'd3,
        S_HOLD  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam int PW = ((CNT_WIDTH > DELAY_WIDTH) ? CNT_WIDTH : DELAY_WIDTH) + 3;
    localparam logic [CNT_WIDTH-1:0] N_MAX = CNT_WIDTH'(DATA_WIDTH);

    state_t                   state, state_d;
    logic [PW-1:0]            cnt, cnt_d;
    logic [TIMEOUT_WIDTH-1:0] tcnt, tcnt_d, tcnt_inc;
    logic [CNT_WIDTH-1:0]     n_q, n_d;
    logic [DELAY_WIDTH-1:0]   d_q, d_d;
    logic                     msb_q, msb_d;
    logic [TIMEOUT_WIDTH-1:0] to_q, to_d;
    logic [DATA_WIDTH-1:0]    sr, sr_rev, n_mask, data_d;
    logic                     terr_d;

    assign dbg_state = state;
    assign n_mask    = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - int'(n_q));

    // Bit-reversed view so LSB-first words line up with a plain right shift.
    always_comb begin
        sr_rev = '0;
        for (int j = 0; j < DATA_WIDTH; j++) begin
            sr_rev[j] = sr[DATA_WIDTH-1-j];
        end
    end

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        tcnt_d   = tcnt;
        n_d      = n_q;
        d_d      = d_q;
        msb_d    = msb_q;
        to_d     = to_q;
        data_d   = TLU_DATA;
        terr_d   = 1'b0;
        tcnt_inc = (tcnt == '1) ? tcnt : tcnt + TIMEOUT_WIDTH'(1);
        case (state)
            S_IDLE: begin
                cnt_d = '0;
                if (START) begin
                    state_d = S_CLOCK;
                    n_d     = (CFG_CLOCK_CYCLES == '0 || CFG_CLOCK_CYCLES > N_MAX) ? N_MAX : CFG_CLOCK_CYCLES;
                    d_d     = CFG_DATA_DELAY;
                    msb_d   = CFG_MSB_FIRST;
                    to_d    = CFG_TIMEOUT;
                end
            end
            S_CLOCK: begin
                if (cnt == PW'(n_q) - PW'(1)) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt + PW'(1);
                end
            end
            S_WAIT: begin
                // Five fixed cycles cover the TLU sync and I/O round trip, on top of the configured delay.
                if (cnt == PW'(d_q) + PW'(4)) begin
                    cnt_d   = '0;
                    state_d = S_LATCH;
                end else begin
                    cnt_d = cnt + PW'(1);
                end
            end
            S_LATCH: begin
                state_d = S_HOLD;
                tcnt_d  = '0;
                data_d  = msb_q ? (sr & n_mask) : (sr_rev >> (DATA_WIDTH - int'(n_q)));
            end
            S_HOLD: begin
                if (DATA_READY) begin
                    state_d = S_DONE;
                    data_d  = '0;
                end else if (to_q != '0) begin
                    tcnt_d = tcnt_inc;
                    if (tcnt_inc == to_q) begin
                        terr_d  = 1'b1;
                        state_d = S_IDLE;
                        data_d  = '0;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state            <= S_IDLE;
            cnt              <= '0;
            tcnt             <= '0;
            n_q              <= '0;
            d_q              <= '0;
            msb_q            <= 1'b0;
            to_q             <= '0;
            sr               <= '0;
            TLU_CLOCK_ENABLE <= 1'b0;
            BUSY             <= 1'b0;
            TLU_DATA         <= '0;
            DATA_VALID       <= 1'b0;
            DONE             <= 1'b0;
            TIMEOUT_ERR      <= 1'b0;
        end else begin
            state            <= state_d;
            cnt              <= cnt_d;
            tcnt             <= tcnt_d;
            n_q              <= n_d;
            d_q              <= d_d;
            msb_q            <= msb_d;
            to_q             <= to_d;
            sr               <= DATA_WIDTH'({sr, TLU_TRIGGER});
            TLU_CLOCK_ENABLE <= (state_d == S_CLOCK);
            BUSY             <= (state_d != S_IDLE);
            TLU_DATA         <= data_d;
            DATA_VALID       <= (state_d == S_HOLD);
            DONE             <= (state_d == S_DONE);
            TIMEOUT_ERR      <= terr_d;
        end
    end

`ifdef TLU_SEQ_CHECK_EN
    logic [DATA_WIDTH-1:0] ref_q;
    logic                  have_ref;
    logic                  accept;

    assign accept = (state == S_HOLD) && DATA_READY;

    // A dropped word breaks the chain, so the next accepted word starts a fresh reference.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ref_q    <= '0;
            have_ref <= 1'b0;
            SEQ_ERR  <= 1'b0;
        end else begin
            SEQ_ERR <= accept && have_ref && (TLU_DATA != ((ref_q + DATA_WIDTH'(1)) & n_mask));
            if (accept) begin
                ref_q    <= TLU_DATA;
                have_ref <= 1'b1;
            end else if (terr_d) begin
                have_ref <= 1'b0;
            end
        end
    end
`else
    assign SEQ_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_tlu_trigger_data_receiver.sv
// Bench for tlu_trigger_data_receiver: TLU serial model, directed transactions, queue-based scoreboard.
// Expected SEQ_ERR follows the TLU_SEQ_CHECK_EN build macro.
module tb_tlu_trigger_data_receiver;

    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          RESET_N;
    logic [5:0]    CFG_CLOCK_CYCLES;
    logic [3:0]    CFG_DATA_DELAY;
    logic          CFG_MSB_FIRST;
    logic [15:0]   CFG_TIMEOUT;
    logic          TLU_TRIGGER;
    logic          START;
    logic          TLU_CLOCK_ENABLE;
    logic          BUSY;
    logic [DW-1:0] TLU_DATA;
    logic          DATA_VALID;
    logic          DATA_READY;
    logic          DONE;
    logic          TIMEOUT_ERR;
    logic          SEQ_ERR;
    logic [2:0]    dbg_state;

    tlu_trigger_data_receiver dut (
        .CLK              (CLK),
        .RESET_N          (RESET_N),
        .CFG_CLOCK_CYCLES (CFG_CLOCK_CYCLES),
        .CFG_DATA_DELAY   (CFG_DATA_DELAY),
        .CFG_MSB_FIRST    (CFG_MSB_FIRST),
        .CFG_TIMEOUT      (CFG_TIMEOUT),
        .TLU_TRIGGER      (TLU_TRIGGER),
        .START            (START),
        .TLU_CLOCK_ENABLE (TLU_CLOCK_ENABLE),
        .BUSY             (BUSY),
        .TLU_DATA         (TLU_DATA),
        .DATA_VALID       (DATA_VALID),
        .DATA_READY       (DATA_READY),
        .DONE             (DONE),
        .TIMEOUT_ERR      (TIMEOUT_ERR),
        .SEQ_ERR          (SEQ_ERR),
        .dbg_state        (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];
    logic [4:0]    evt_q[$];    // {DONE, TIMEOUT_ERR, SEQ_ERR, BUSY, DATA_VALID}

    logic [DW-1:0] ref_m = '0;
    logic          have_ref_m = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- TLU serial model ----------------
    // Bit k goes out on the k-th enabled cycle and reaches the receiver after a tlu_lat-cycle round trip.
    logic [DW-1:0] tlu_word = '0;
    logic          tlu_msb = 1'b0;
    int            tlu_n = 1;
    int            tlu_lat = 5;
    int            tlu_k = 0;
    logic [63:0]   tline = '1;

    always @(negedge CLK) begin
        logic b;
        b = 1'b1;
        if (TLU_CLOCK_ENABLE && tlu_k < tlu_n) begin
            b = tlu_msb ? tlu_word[tlu_n-1-tlu_k] : tlu_word[tlu_k];
            tlu_k++;
        end
        tline = {tline[62:0], b};
        TLU_TRIGGER = tline[tlu_lat];
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge CLK) begin
        #1;
        if (RESET_N) begin
            if (DATA_VALID && DATA_READY) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL handshake_unexpected actual=%0h required=none", TLU_DATA);
                end else begin
                    check("data", TLU_DATA, exp_q.pop_front());
                end
            end
            if (DONE || TIMEOUT_ERR) begin
                if (evt_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL event_unexpected actual=%b required=none",
                             {DONE, TIMEOUT_ERR, SEQ_ERR, BUSY, DATA_VALID});
                end else begin
                    check("event_done_terr_seq_busy_valid",
                          {DONE, TIMEOUT_ERR, SEQ_ERR, BUSY, DATA_VALID}, evt_q.pop_front());
                end
            end else if (SEQ_ERR) begin
                checks++; errors++;
                $display("FAIL seq_err_stray actual=1 required=0");
            end
        end
    end

    // ---------------- driver ----------------
    task automatic run_txn(input logic [5:0] cfg_n, input logic [3:0] d, input logic msb,
                           input logic [15:0] to, input logic [DW-1:0] word, input int r,
                           input bit abort);
        int n_eff, cnt, lat, h;
        bit exp_to;
        logic [DW-1:0] mask, w;
        logic seq;
        n_eff  = (cfg_n == 0 || cfg_n > 32) ? 32 : int'(cfg_n);
        mask   = (n_eff == 32) ? '1 : ((32'd1 << n_eff) - 32'd1);
        w      = word & mask;
        exp_to = (to != 0) && (r == 0 || r > int'(to));
        if (!abort) begin
            if (exp_to) begin
                evt_q.push_back(5'b01000);
                have_ref_m = 1'b0;
            end else begin
                seq = have_ref_m && (w != ((ref_m + 32'd1) & mask));
`ifndef TLU_SEQ_CHECK_EN
                seq = 1'b0;
`endif
                exp_q.push_back(w);
                evt_q.push_back({1'b1, 1'b0, seq, 1'b1, 1'b0});
                ref_m      = w;
                have_ref_m = 1'b1;
            end
        end

        @(negedge CLK);
        CFG_CLOCK_CYCLES = cfg_n;
        CFG_DATA_DELAY   = d;
        CFG_MSB_FIRST    = msb;
        CFG_TIMEOUT      = to;
        tlu_word = word;
        tlu_msb  = msb;
        tlu_n    = n_eff;
        tlu_lat  = int'(d) + 5;
        tlu_k    = 0;
        START    = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        // Scramble the config inputs: the captured copy must be used.
        CFG_CLOCK_CYCLES = 6'd3;
        CFG_DATA_DELAY   = 4'd9;
        CFG_MSB_FIRST    = ~msb;
        CFG_TIMEOUT      = 16'd1;

        cnt = 0;
        while (TLU_CLOCK_ENABLE && cnt < 100) begin
            cnt++;
            START = (abort && cnt == 3);
            @(negedge CLK);
        end
        START = 1'b0;
        check("enable_cycles", cnt, n_eff);

        if (abort) begin
            @(negedge CLK);
            @(negedge CLK);
            RESET_N = 1'b0;
            #1;
            check("abort_outputs_zero",
                  {TLU_CLOCK_ENABLE, BUSY, DATA_VALID, DONE, TIMEOUT_ERR, SEQ_ERR, TLU_DATA, dbg_state}, 0);
            @(negedge CLK);
            RESET_N    = 1'b1;
            have_ref_m = 1'b0;
            @(negedge CLK);
            check("abort_idle_after", {BUSY, DONE, TIMEOUT_ERR, dbg_state}, 0);
            return;
        end

        lat = 0;
        while (!DATA_VALID && lat < 100) begin
            @(negedge CLK);
            lat++;
        end
        check("valid_latency", lat, int'(d) + 6);

        h = 1;
        while (!DONE && !TIMEOUT_ERR && h < 200) begin
            DATA_READY = (r != 0 && h >= r);
            @(negedge CLK);
            h++;
        end
        DATA_READY = 1'b0;
        check("end_cycle", h, exp_to ? int'(to) + 1 : r + 1);
        @(negedge CLK);
        check("idle_after", {BUSY, DONE, TIMEOUT_ERR, DATA_VALID}, 0);
    endtask

    initial begin
        RESET_N          = 1'b0;
        START            = 1'b0;
        DATA_READY       = 1'b0;
        CFG_CLOCK_CYCLES = '0;
        CFG_DATA_DELAY   = '0;
        CFG_MSB_FIRST    = 1'b0;
        CFG_TIMEOUT      = '0;
        TLU_TRIGGER      = 1'b1;
        repeat (3) @(negedge CLK);
        check("reset_outputs",
              {TLU_CLOCK_ENABLE, BUSY, DATA_VALID, DONE, TIMEOUT_ERR, SEQ_ERR, TLU_DATA, dbg_state}, 0);
        RESET_N = 1'b1;
        repeat (2) @(negedge CLK);

        //       cfg_n  d     msb   to      word          r   abort
        run_txn(6'd32, 4'd0, 1'b1, 16'd0,  32'hDEADBEEF, 1,  1'b0);
        run_txn(6'd15, 4'd2, 1'b0, 16'd0,  32'h00001234, 3,  1'b0);
        run_txn(6'd8,  4'd1, 1'b1, 16'd10, 32'h000000A5, 0,  1'b0);
        run_txn(6'd8,  4'd0, 1'b0, 16'd10, 32'h0000003C, 10, 1'b0);
        run_txn(6'd8,  4'd0, 1'b1, 16'd0,  32'h00000077, 1,  1'b1);
        run_txn(6'd0,  4'd3, 1'b0, 16'd0,  32'h89ABCDEF, 2,  1'b0);
        run_txn(6'd40, 4'd0, 1'b1, 16'd0,  32'h00000004, 1,  1'b0);
        run_txn(6'd8,  4'd0, 1'b1, 16'd0,  32'h00000005, 1,  1'b0);
        run_txn(6'd8,  4'd0, 1'b0, 16'd0,  32'h00000006, 2,  1'b0);
        run_txn(6'd8,  4'd0, 1'b1, 16'd0,  32'h00000008, 1,  1'b0);
        run_txn(6'd1,  4'd15, 1'b1, 16'd0, 32'h00000001, 1,  1'b0);

        repeat (4) @(negedge CLK);
        check("exp_q_drained", exp_q.size(), 0);
        check("evt_q_drained", evt_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
